aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES round sequencer driving the shared round datapath (SubBytes/ShiftRows/mixColumns/AddRoundKey). The mixColumns stage is registered.
- Accepts a start request, issues one load pulse, then NR round-step pulses spaced by the datapath latency. Clears mix enable on the final round, then holds a done handshake.
- Sits between the top-level command interface and the round datapath/key-schedule RAM.

Parameters:
- NR, 10, number of AES rounds (10/12/14); legal range 1..14.
- DP_LAT, 1, round datapath latency in cycles from dp_step to result registered; legal 1..8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  request to encrypt the block present on the datapath input
- start_ready  output  1  controller can accept start (combinational)
- key_rdy  input  1  expanded key schedule valid
- abort  input  1  synchronous abort; returns to IDLE
- dp_load  output  1  one-cycle pulse: datapath loads input ^ round key 0
- dp_step  output  1  one-cycle pulse: datapath performs one round
- dp_round  output  4  current round number (0 during load)
- dp_key_idx  output  4  round-key index to read (equals dp_round)
- dp_mix_en  output  1  1 = apply mixColumns this round; 0 = bypass
- busy  output  1  high in every state except IDLE
- done_valid  output  1  ciphertext valid on datapath output
- done_ready  input  1  consumer accepts ciphertext

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0 except start_ready, which follows IDLE & key_rdy.
  - Round counter = 0 and wait counter = 0.
- States: IDLE, LOAD, ROUND, WAIT, DONE.
- IDLE:
  - start_ready = key_rdy.
  - Accept on start_valid & start_ready (cycle T) -> LOAD.
  - start_valid with key_rdy=0 is not accepted; the controller stays in IDLE.
- LOAD (T+1): dp_load=1, dp_round=0, dp_key_idx=0 -> ROUND with r=1.
- ROUND:
  - dp_step=1 for exactly one cycle.
  - dp_round=r, dp_key_idx=r, dp_mix_en=(r!=NR).
  - If DP_LAT=1: next state is ROUND with r+1, or DONE if r=NR.
  - Else: WAIT, with the wait counter loaded to DP_LAT-1.
- WAIT:
  - dp_step=0; dp_round and dp_key_idx hold r; dp_mix_en holds its value.
  - The wait counter decrements each cycle.
  - On the cycle the counter reaches 1: go to ROUND with r+1, or DONE if r=NR.
- Timing: round r step fires at T+2+(r-1)*DP_LAT; done_valid first asserts at T+2+NR*DP_LAT.
- DONE:
  - done_valid=1, held stable until done_ready=1.
  - Handshake cycle -> IDLE; done_valid=0 next cycle.
  - A new start can be accepted in the first IDLE cycle after DONE.
- start_ready=0 in every non-IDLE state. start_valid is ignored there; no queuing.
- abort:
  - Any non-IDLE state -> IDLE next cycle; done_valid is never asserted for that block.
  - Abort in IDLE has no effect.
  - abort and done_ready in the same DONE cycle: result is IDLE (abort wins, same outcome).
  - abort in IDLE blocks acceptance that cycle (start_ready=0 while abort=1).
- Round counter is 4-bit and never exceeds NR. Wait counter is 3-bit and never wraps.
- key_rdy dropping mid-operation is ignored; the operation runs to completion.
- dp_load and dp_step are never high in the same cycle.
- Async reset mid-operation: immediate IDLE; no further pulses.

Optional Feature:
- Macro: AES_DUMMY_ROUND_EN.
- When defined:
  - Adds ports dummy_req (input, 1) and dp_dummy (output, 1).
  - dummy_req is sampled at start acceptance. If it was 1, one dummy round is inserted between LOAD and round 1.
  - During the dummy round: dp_step=1, dp_dummy=1, dp_round=0, dp_key_idx=0, dp_mix_en=1. It is followed by the normal WAIT spacing.
  - The datapath discards the dummy result.
  - Total latency increases by DP_LAT; done_valid at T+2+(NR+1)*DP_LAT.
- When undefined: no extra ports, no dummy state, latency as above.

Test Plan:
- NR=10, DP_LAT=1, key_rdy=1, start at cycle 0 -> dp_load@1; dp_step@2..11 with dp_round 1..10; dp_mix_en=1 for rounds 1..9 and 0 for round 10; done_valid@12.
- DP_LAT=3, NR=10 -> dp_step@2,5,...,29 (10 pulses); done_valid@32; dp_round holds between steps.
- done_ready held 0 for 5 cycles in DONE -> done_valid stays 1, start_ready=0. Then done_ready=1 -> IDLE next cycle; back-to-back start accepted immediately and dp_load fires the following cycle.
- abort asserted at round 4 -> IDLE next cycle, no further dp_step, done_valid never rises. Also: start_valid with key_rdy=0 -> no dp_load.
- rst_n low during WAIT (DP_LAT=3, round 6) -> all outputs 0 asynchronously. After release, a new start runs a full NR=10 rounds from round 1.
- AES_DUMMY_ROUND_EN, dummy_req=1, DP_LAT=1 -> dummy step@2 with dp_dummy=1 and dp_round=0; real rounds@3..12; done_valid@13.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer (load, NR spaced round steps, done handshake); AES_DUMMY_ROUND_EN adds an optional leading dummy round
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       key_rdy,
    input  logic       abort,
`ifdef AES_DUMMY_ROUND_EN
    input  logic       dummy_req,
    output logic       dp_dummy,
`endif
    output logic       dp_load,
    output logic       dp_step,
    output logic [3:0] dp_round,
    output logic [3:0] dp_key_idx,
    output logic       dp_mix_en,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, WAIT, DONE} state_t;
    state_t     state, state_d;
    logic [3:0] rnd, rnd_d;
    logic [2:0] wcnt, wcnt_d;
    logic       dum;
    logic       last;
    assign last       = rnd == 4'(NR);
    assign dp_round   = rnd;
    assign dp_key_idx = rnd;
`ifdef AES_DUMMY_ROUND_EN
    // the dummy round is a ROUND step carrying round number 0
    assign dp_dummy = (state == ROUND) && (rnd == 4'd0);
    // latch dummy_req while idle so the value at acceptance is kept
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dum <= 1'b0;
        else if (state == IDLE) dum <= dummy_req;
`else
    assign dum = 1'b0;
`endif
    // next-state, counters and datapath strobes
    always_comb begin
        state_d     = state;
        rnd_d       = rnd;
        wcnt_d      = wcnt;
        start_ready = 1'b0;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        dp_mix_en   = 1'b0;
        done_valid  = 1'b0;
        busy        = state != IDLE;
        case (state)
            IDLE: begin
                start_ready = key_rdy & ~abort;
                if (start_valid && start_ready) state_d = LOAD;
            end
            LOAD: begin
                dp_load = 1'b1;
                rnd_d   = dum ? 4'd0 : 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                dp_step   = 1'b1;
                dp_mix_en = !last;
                if (DP_LAT == 1) begin
                    state_d = last ? DONE : ROUND;
                    rnd_d   = last ? rnd : rnd + 4'd1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = 3'(DP_LAT - 1);
                end
            end
            WAIT: begin
                dp_mix_en = !last;
                wcnt_d    = wcnt - 3'd1;
                if (wcnt == 3'd1) begin
                    state_d = last ? DONE : ROUND;
                    rnd_d   = last ? rnd : rnd + 4'd1;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) state_d = IDLE;
        if (state_d == IDLE) begin
            rnd_d  = 4'd0;
            wcnt_d = 3'd0;
        end
    end
    // state and counter registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= 4'd0;
            wcnt  <= 3'd0;
        end else begin
            state <= state_d;
            rnd   <= rnd_d;
            wcnt  <= wcnt_d;
        end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized check of three aes_round_ctrl configurations against a cycle-offset reference model
module tb_aes_round_ctrl;
    localparam int N = 3;
    function automatic int nr_of(input int k);
        return k == 2 ? 1 : 10;
    endfunction
    function automatic int lat_of(input int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 8);
    endfunction
    logic clk = 1'b0;
    logic rst_n, start_valid, key_rdy, abort, done_ready;
`ifdef AES_DUMMY_ROUND_EN
    logic dummy_req;
    logic dd[N];
`endif
    logic sr[N], ld[N], st[N], mx[N], bz[N], dv[N];
    logic [3:0] rd[N], ki[N];
    int n_chk = 0, n_err = 0;
    bit act[N];
    int e[N], d[N];
    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) begin : g_dut
        aes_round_ctrl #(.NR(nr_of(g)), .DP_LAT(lat_of(g))) u (
            .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[g]),
            .key_rdy(key_rdy), .abort(abort),
`ifdef AES_DUMMY_ROUND_EN
            .dummy_req(dummy_req), .dp_dummy(dd[g]),
`endif
            .dp_load(ld[g]), .dp_step(st[g]), .dp_round(rd[g]), .dp_key_idx(ki[g]),
            .dp_mix_en(mx[g]), .busy(bz[g]), .done_valid(dv[g]), .done_ready(done_ready)
        );
    end
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic check_reset();
        for (int k = 0; k < N; k++) begin
            check($sformatf("u%0d.rst_busy", k), int'(bz[k]), 0);
            check($sformatf("u%0d.rst_load", k), int'(ld[k]), 0);
            check($sformatf("u%0d.rst_step", k), int'(st[k]), 0);
            check($sformatf("u%0d.rst_mix", k), int'(mx[k]), 0);
            check($sformatf("u%0d.rst_done", k), int'(dv[k]), 0);
            check($sformatf("u%0d.rst_round", k), int'(rd[k]), 0);
            check($sformatf("u%0d.rst_kidx", k), int'(ki[k]), 0);
            act[k] = 1'b0;
        end
    endtask
    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        key_rdy = 1'b0;
        abort = 1'b0;
        done_ready = 1'b0;
`ifdef AES_DUMMY_ROUND_EN
        dummy_req = 1'b0;
`endif
        #3;
        check_reset();
        for (int k = 0; k < N; k++) check($sformatf("u%0d.rst_sready", k), int'(sr[k]), 0);
        #4 rst_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            key_rdy     = $urandom_range(0, 99) < 85;
            abort       = $urandom_range(0, 199) < 2;
            done_ready  = $urandom_range(0, 99) < 30;
`ifdef AES_DUMMY_ROUND_EN
            dummy_req   = 1'($urandom_range(0, 1));
`endif
            #1;
            for (int k = 0; k < N; k++) begin
                int lat, nr, da, j, ex_rd;
                bit ex_sr, ex_ld, ex_st, ex_mx, ex_dv, ex_dd;
                lat = lat_of(k);
                nr = nr_of(k);
                da = 2 + (nr + d[k]) * lat;
                ex_sr = 0; ex_ld = 0; ex_st = 0; ex_mx = 0; ex_dv = 0; ex_dd = 0; ex_rd = -1;
                if (!act[k]) ex_sr = key_rdy && !abort;
                else if (e[k] == 1) begin
                    ex_ld = 1;
                    ex_rd = 0;
                end else if (e[k] < da) begin
                    j = (e[k] - 2) / lat;
                    ex_st = ((e[k] - 2) % lat) == 0;
                    ex_rd = j + 1 - d[k];
                    ex_mx = ex_rd != nr;
                    ex_dd = ex_st && d[k] == 1 && j == 0;
                end else ex_dv = 1;
                check($sformatf("u%0d.sready", k), int'(sr[k]), int'(ex_sr));
                check($sformatf("u%0d.busy", k), int'(bz[k]), int'(act[k]));
                check($sformatf("u%0d.load", k), int'(ld[k]), int'(ex_ld));
                check($sformatf("u%0d.step", k), int'(st[k]), int'(ex_st));
                check($sformatf("u%0d.mix", k), int'(mx[k]), int'(ex_mx));
                check($sformatf("u%0d.done", k), int'(dv[k]), int'(ex_dv));
`ifdef AES_DUMMY_ROUND_EN
                check($sformatf("u%0d.dummy", k), int'(dd[k]), int'(ex_dd));
`endif
                if (ex_rd >= 0) begin
                    check($sformatf("u%0d.round", k), int'(rd[k]), ex_rd);
                    check($sformatf("u%0d.kidx", k), int'(ki[k]), ex_rd);
                end
                if (!act[k]) begin
                    if (start_valid && key_rdy && !abort) begin
                        act[k] = 1'b1;
                        e[k] = 1;
`ifdef AES_DUMMY_ROUND_EN
                        d[k] = int'(dummy_req);
`else
                        d[k] = 0;
`endif
                    end
                end else if (abort || (e[k] >= da && done_ready)) act[k] = 1'b0;
                else e[k]++;
            end
            if (cyc % 900 == 450) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_reset();
                #1 rst_n = 1'b1;
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
